// File: rtl/balu_24.sv
// balu_24: registered 24-bit ALU (add/sub/div/rem/AND/OR/XOR/XNOR); optional zero/div_zero flags under BALU_24_STATUS_EN.
// Latency 1 cycle from operand sample to out; no backpressure, a new operation is accepted every clock.
module balu_24 #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       select,
  output logic [WIDTH:0]   out
`ifdef BALU_24_STATUS_EN
  ,
  output logic             zero,
  output logic             div_zero
`endif
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   result;

  // Unrolled restoring divider. With in2 == 0 every trial subtract succeeds,
  // which yields an all-ones quotient and leaves in1 as the remainder.
  always_comb begin
    quo  = '0;
    part = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      part = {part[WIDTH-1:0], in1[i]};
      if (part >= {1'b0, in2}) begin
        part   = part - {1'b0, in2};
        quo[i] = 1'b1;
      end
    end
  end

  always_comb begin
    result = '0;
    case (select)
      3'b000:  result = {1'b0, in1} + {1'b0, in2};
      3'b001:  result = {1'b0, in1} - {1'b0, in2};
      3'b010:  result = {1'b0, quo};
      3'b011:  result = {1'b0, part[WIDTH-1:0]};
      3'b100:  result = {1'b0, in1 & in2};
      3'b101:  result = {1'b0, in1 | in2};
      3'b110:  result = {1'b0, in1 ^ in2};
      default: result = {1'b0, ~(in1 ^ in2)};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= result;
    end
  end

`ifdef BALU_24_STATUS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      zero     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      zero     <= (result == '0);
      div_zero <= (select[2:1] == 2'b01) && (in2 == '0);
    end
  end
`endif

endmodule

// File: tb/tb_balu_24.sv
// Randomized and directed bench for balu_24 against an arithmetic reference model.
module tb_balu_24;

  logic        clock;
  logic        reset;
  logic [23:0] in1;
  logic [23:0] in2;
  logic [2:0]  select;
  logic [24:0] out;
`ifdef BALU_24_STATUS_EN
  logic        zero;
  logic        div_zero;
`endif

  int errors = 0;
  int checks = 0;

  logic [24:0] exp_out;
  logic        exp_zero;
  logic        exp_dz;
  logic        exp_vld = 1'b0;

  balu_24 dut (
    .clock   (clock),
    .reset   (reset),
    .in1     (in1),
    .in2     (in2),
    .select  (select),
    .out     (out)
`ifdef BALU_24_STATUS_EN
    ,
    .zero    (zero),
    .div_zero(div_zero)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [24:0] model(input logic [2:0] s, input logic [23:0] a, input logic [23:0] b);
    longint ua;
    longint ub;
    longint r;
    ua = longint'(a);
    ub = longint'(b);
    case (s)
      3'd0:    r = ua + ub;
      3'd1:    r = ua - ub;
      3'd2:    r = (ub == 0) ? 64'hFFFFFF : ua / ub;
      3'd3:    r = (ub == 0) ? ua : ua % ub;
      3'd4:    r = ua & ub;
      3'd5:    r = ua | ub;
      3'd6:    r = ua ^ ub;
      default: r = (ua ^ ub) ^ 64'hFFFFFF;
    endcase
    return r[24:0];
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Model register: what the DUT must show after each edge.
  always @(posedge clock) begin
    exp_out  <= reset ? 25'd0 : model(select, in1, in2);
    exp_zero <= reset ? 1'b0 : (model(select, in1, in2) == 25'd0);
    exp_dz   <= reset ? 1'b0 : ((select == 3'd2 || select == 3'd3) && in2 == 24'd0);
    exp_vld  <= 1'b1;
  end

  always @(negedge clock) begin
    if (exp_vld) begin
      check("cycle_out", out, exp_out);
`ifdef BALU_24_STATUS_EN
      check("cycle_zero", {24'd0, zero}, {24'd0, exp_zero});
      check("cycle_div_zero", {24'd0, div_zero}, {24'd0, exp_dz});
`endif
    end
  end

  task automatic apply(input logic [2:0] s, input logic [23:0] a, input logic [23:0] b,
                       input logic [24:0] lit, input string name);
    @(negedge clock);
    reset  = 1'b0;
    select = s;
    in1    = a;
    in2    = b;
    @(posedge clock);
    #1;
    check(name, out, lit);
    check({name, "_model"}, model(s, a, b), lit);
  endtask

  function automatic logic [23:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 24'd0;
      1:       return 24'hFFFFFF;
      2:       return 24'($urandom_range(0, 15));
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    reset  = 1'b1;
    in1    = 24'hABCDEF;
    in2    = 24'h123456;
    select = 3'd2;
    repeat (2) @(posedge clock);
    #1;
    check("reset_out", out, 25'd0);

    apply(3'd0, 24'hF53586, 24'hF53581, 25'h1EA6B07, "add");
    apply(3'd1, 24'hF53586, 24'hF53581, 25'h0000005, "sub");
    apply(3'd2, 24'hF53586, 24'hF53581, 25'h0000001, "div");
    apply(3'd3, 24'hF53586, 24'hF53581, 25'h0000005, "rem");
    apply(3'd4, 24'hF53586, 24'hF53581, 25'h0F53580, "and");
    apply(3'd5, 24'hF53586, 24'hF53581, 25'h0F53587, "or");
    apply(3'd6, 24'hF53586, 24'hF53581, 25'h0000007, "xor");
    apply(3'd7, 24'hF53586, 24'hF53581, 25'h0FFFFF8, "xnor");
    apply(3'd1, 24'd3, 24'd5, 25'h1FFFFFE, "borrow");
    apply(3'd0, 24'hFFFFFF, 24'hFFFFFF, 25'h1FFFFFE, "carry");
    apply(3'd2, 24'h123456, 24'd0, 25'h0FFFFFF, "div_by_zero");
`ifdef BALU_24_STATUS_EN
    check("div_by_zero_flag", {24'd0, div_zero}, 25'd1);
`endif
    apply(3'd3, 24'h123456, 24'd0, 25'h0123456, "rem_by_zero");
`ifdef BALU_24_STATUS_EN
    check("rem_by_zero_flag", {24'd0, div_zero}, 25'd1);
`endif
    apply(3'd2, 24'd1000, 24'd7, 25'd142, "div_small");
    apply(3'd3, 24'd1000, 24'd7, 25'd6, "rem_small");

    // Mid-stream reset during an add must win over the operation.
    @(negedge clock);
    select = 3'd0;
    in1    = 24'h000010;
    in2    = 24'h000020;
    reset  = 1'b1;
    @(posedge clock);
    #1;
    check("reset_midstream", out, 25'd0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset  = ($urandom_range(0, 49) == 0);
      select = 3'($urandom_range(0, 7));
      in1    = pick_operand();
      in2    = ($urandom_range(0, 9) == 0) ? in1 : pick_operand();
    end

    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
